sr_latch_arbiter: RTL and testbench



---
 rtl/sr_latch_arbiter_pkg.sv | 23 ++
 rtl/sr_latch_arbiter_rr_pick.sv | 35 +++
 rtl/sr_latch_arbiter.sv | 133 +++++++++++++
 tb/tb_sr_latch_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sr_latch_arbiter_pkg.sv
// Shared types and defaults for the SR latch arbiter: FSM state encoding,
// default parameter values and a constant clog2 helper.
package sr_latch_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_PULSE_CYC = 2;
  localparam int DEF_GAP_CYC   = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sr_latch_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// searching upward with wrap-around.
module rr_pick
  import sr_latch_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PTR_W = clog2(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [PTR_W-1:0] idx_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] pos;

  // Scan farthest-first so the nearest hit to ptr_i is the last one written.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    sum     = '0;
    pos     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
      pos = sum[PTR_W-1:0];
      if (req_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/sr_latch_arbiter.sv
// Round-robin arbiter sharing one SR latch between N_REQ requesters.
// Optional readback check of the latch output enabled by SR_ARB_READBACK_EN.
module sr_latch_arbiter
  import sr_latch_arbiter_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int GAP_CYC   = DEF_GAP_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] op,
  output logic [N_REQ-1:0] ack,
  output logic             busy,
  output logic             latch_s,
  output logic             latch_r,
  input  logic             latch_q,
  output logic             err
);

  localparam int PTR_W = clog2(N_REQ);
  localparam int CNT_W = clog2((PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC) + 1;
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] g_q, g_d;
  logic             op_g_q, op_g_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             err_q, err_d;
  logic             pick_vld;
  logic [PTR_W-1:0] pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .idx_o   (pick_idx)
  );

  // Counter is reloaded on every state entry and counts down to zero.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    op_g_d  = op_g_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          g_d     = pick_idx;
          op_g_d  = op[pick_idx];
          cnt_d   = PULSE_LD;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LD;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        ptr_d   = (g_q == LAST_IDX) ? '0 : g_q + 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Drives are decoded from the next state so they rise on DRIVE entry;
    // set and reset come from one bit and its complement, never both.
    s_d = (state_d == ST_DRIVE) &  op_g_d;
    r_d = (state_d == ST_DRIVE) & ~op_g_d;
  end

`ifdef SR_ARB_READBACK_EN
  always_comb begin
    err_d = err_q;
    if ((state_q == ST_ACK) && (latch_q != op_g_q)) err_d = 1'b1;
  end
`else
  logic unused_latch_q;
  assign unused_latch_q = latch_q;
  assign err_d          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      g_q     <= '0;
      op_g_q  <= 1'b0;
      cnt_q   <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      op_g_q  <= op_g_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      err_q   <= err_d;
    end
  end

  assign ack     = (state_q == ST_ACK) ? (N_REQ'(1) << g_q) : '0;
  assign busy    = (state_q != ST_IDLE);
  assign latch_s = s_q;
  assign latch_r = r_q;
  assign err     = err_q;

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Scoreboard bench for sr_latch_arbiter with a behavioural SR latch model.
module tb_sr_latch_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] op;
  logic [3:0] ack;
  logic       busy;
  logic       latch_s;
  logic       latch_r;
  logic       latch_q;
  logic       err;

  logic       mq = 1'b0;
  logic       force_zero = 1'b0;
  logic       skip_pw = 1'b0;
  int         cyc = 0;
  int         run = 0;
  int         n_chk = 0;
  int         n_fail = 0;

  typedef struct {
    logic [3:0] a;
    int         c;
    logic       q;
  } exp_t;
  exp_t sb[$];

  sr_latch_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op      (op),
    .ack     (ack),
    .busy    (busy),
    .latch_s (latch_s),
    .latch_r (latch_r),
    .latch_q (latch_q),
    .err     (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (latch_s)      mq <= 1'b1;
    else if (latch_r) mq <= 1'b0;
  end
  assign latch_q = force_zero ? 1'b0 : mq;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every ack, checks invariants each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (ack != 4'b0) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack: got %b expected none (cycle %0d)", ack, cyc);
      end else begin
        e = sb.pop_front();
        chk("ack_vec", int'(ack), int'(e.a));
        chk("ack_cycle", cyc, e.c);
        chk("latch_val", int'(mq), int'(e.q));
        chk("busy_at_ack", int'(busy), 1);
      end
    end
    chk("s_and_r_exclusive", int'(latch_s & latch_r), 0);
    if (latch_s | latch_r) begin
      run++;
    end else if (run > 0) begin
      if (!skip_pw) chk("pulse_width", run, 2);
      run = 0;
    end
  end

  task automatic wait_ack();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ack != 4'b0) got = 1'b1;
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack expected one within 40 cycles");
    end
  endtask

  task automatic do_op(input logic [3:0] r, input logic [3:0] o,
                       input logic [3:0] a, input logic q);
    exp_t e;
    @(negedge clk);
    req = r;
    op  = o;
    e.a = a; e.c = cyc + 4; e.q = q;
    sb.push_back(e);
    wait_ack();
    req = 4'b0;
    op  = 4'b0;
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_drives"}, int'({latch_s, latch_r}), 0);
    chk({nm, "_ack"}, int'(ack), 0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1;
    req = 4'b0;
    op  = 4'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    chk("reset_err", int'(err), 0);
    rst = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_quiet("idle");
    end

    // Single set on requester 0, then single reset on requester 2
    do_op(4'b0001, 4'b0001, 4'b0001, 1'b1);
    @(negedge clk);
    chk("after_set_q", int'(mq), 1);
    do_op(4'b0100, 4'b0000, 4'b0100, 1'b0);
    @(negedge clk);
    chk("after_reset_q", int'(mq), 0);
    chk("no_err_normal", int'(err), 0);

    // All four held continuously from ptr 0: rotation with 5-cycle period
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req = 4'b1111;
    op  = 4'b0101;
    e.a = 4'b0001; e.c = cyc + 4;  e.q = 1'b1; sb.push_back(e);
    e.a = 4'b0010; e.c = cyc + 9;  e.q = 1'b0; sb.push_back(e);
    e.a = 4'b0100; e.c = cyc + 14; e.q = 1'b1; sb.push_back(e);
    e.a = 4'b1000; e.c = cyc + 19; e.q = 1'b0; sb.push_back(e);
    e.a = 4'b0001; e.c = cyc + 24; e.q = 1'b1; sb.push_back(e);
    for (int i = 0; i < 5; i++) wait_ack();
    req = 4'b0;
    op  = 4'b0;

    // Reset on the second DRIVE cycle aborts the operation and clears ptr
    @(negedge clk);
    req = 4'b0100;
    op  = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    chk("drive2_set_high", int'(latch_s), 1);
    rst     = 1'b1;
    req     = 4'b0;
    op      = 4'b0;
    skip_pw = 1'b1;
    @(negedge clk);
    check_quiet("abort");
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_ack_busy", int'(busy), 0);
    skip_pw = 1'b0;
    do_op(4'b1001, 4'b1001, 4'b0001, 1'b1);

    // Readback: latch output forced low during a set
    force_zero = 1'b1;
    do_op(4'b0001, 4'b0001, 4'b0001, 1'b1);
    @(negedge clk);
`ifdef SR_ARB_READBACK_EN
    chk("err_set", int'(err), 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", int'(err), 1);
`else
    chk("err_tied_low", int'(err), 0);
    repeat (3) @(negedge clk);
    chk("err_still_low", int'(err), 0);
`endif
    force_zero = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", int'(err), 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
